// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage program counter.
package pc_pkg;

    typedef enum logic [2:0] {
        INC  = 3'd0,
        JMP  = 3'd1,
        BRA  = 3'd2,
        CALL = 3'd3,
        RET  = 3'd4,
        HOLD = 3'd5
    } pc_op_t;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        OVF   = 3'd1,
        UNF   = 3'd2,
        ILL   = 3'd3,
        BOUND = 3'd4
    } pc_err_t;

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between the fetch sequencer and pc_unit.
interface pc_unit_if #(
    parameter int W = 8
) ();
    import pc_pkg::*;

    logic          ld;
    pc_op_t        op;
    logic [W-1:0]  target;
    logic [W-1:0]  offset;
    logic          err_clr;
    logic [W-1:0]  pc;
    logic [W-1:0]  next_pc;
    logic          stk_full;
    logic          stk_empty;
    logic          err;
    pc_err_t       err_code;

    modport master (
        output ld, op, target, offset, err_clr,
        input  pc, next_pc, stk_full, stk_empty, err, err_code
    );

    modport slave (
        input  ld, op, target, offset, err_clr,
        output pc, next_pc, stk_full, stk_empty, err, err_code
    );

endinterface

// File: rtl/pc_stack.sv
// LIFO return-address stack; dout always shows the top entry.
module pc_stack #(
    parameter int W           = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int SPW   = $clog2(STACK_DEPTH + 1);
    localparam int SLOTS = 2 ** SPW;

    logic [SPW-1:0] sp_q, sp_d;
    logic [SPW-1:0] top;
    logic [W-1:0]   mem_q [SLOTS];
    logic [W-1:0]   mem_d [SLOTS];

    assign full  = (sp_q == SPW'(STACK_DEPTH));
    assign empty = (sp_q == '0);
    assign top   = empty ? '0 : sp_q - SPW'(1);
    assign dout  = mem_q[top];

    always_comb begin
        sp_d  = sp_q;
        mem_d = mem_q;
        if (push && !full) begin
            mem_d[sp_q] = din;
            sp_d        = sp_q + SPW'(1);
        end else if (pop && !empty) begin
            sp_d = top;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_q  <= '0;
            mem_q <= '{default: '0};
        end else begin
            sp_q  <= sp_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with jumps, call/return stack and sticky errors.
// Define PC_BOUND_CHECK_EN to suppress targets at or above IMEM_DEPTH.
module pc_unit #(
    parameter int           W           = 8,
    parameter logic [W-1:0] RESET_VEC   = '0,
    parameter int           STACK_DEPTH = 4,
    parameter int           IMEM_DEPTH  = 256
) (
    input  logic      clk,
    input  logic      rst,
    pc_unit_if.slave  bus
);
    import pc_pkg::*;

`ifdef PC_BOUND_CHECK_EN
    localparam bit BOUND_EN = 1'b1;
`else
    localparam bit BOUND_EN = 1'b0;
`endif

    logic [W-1:0] pc_q, pc_d;
    logic         err_q, err_d;
    pc_err_t      code_q, code_d;

    logic [W-1:0] cand;
    logic [W-1:0] stk_top;
    logic         want_push, want_pop;
    logic         full, empty;
    pc_err_t      fault;

    pc_stack #(
        .W           (W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.ld && want_push),
        .pop   (bus.ld && want_pop),
        .din   (pc_q + W'(1)),
        .dout  (stk_top),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        cand      = pc_q;
        fault     = NONE;
        want_push = 1'b0;
        want_pop  = 1'b0;
        unique case (bus.op)
            INC:  cand = pc_q + W'(1);
            JMP:  cand = bus.target;
            BRA:  cand = pc_q + bus.offset;
            CALL: begin
                if (full) begin
                    fault = OVF;
                end else begin
                    cand      = bus.target;
                    want_push = 1'b1;
                end
            end
            RET: begin
                if (empty) begin
                    fault = UNF;
                end else begin
                    cand     = stk_top;
                    want_pop = 1'b1;
                end
            end
            HOLD:    cand  = pc_q;
            default: fault = ILL;
        endcase
        // Out-of-range targets are dropped whole: no pc move, no stack change.
        if (BOUND_EN && fault == NONE && bus.op != HOLD &&
            32'(cand) >= 32'(IMEM_DEPTH)) begin
            fault     = BOUND;
            cand      = pc_q;
            want_push = 1'b0;
            want_pop  = 1'b0;
        end
    end

    always_comb begin
        pc_d   = bus.ld ? cand : pc_q;
        err_d  = err_q;
        code_d = code_q;
        if (bus.err_clr) begin
            err_d  = 1'b0;
            code_d = NONE;
        end
        if (bus.ld && fault != NONE) begin
            err_d = 1'b1;
            if (!err_q || bus.err_clr) begin
                code_d = fault;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q   <= RESET_VEC;
            err_q  <= 1'b0;
            code_q <= NONE;
        end else begin
            pc_q   <= pc_d;
            err_q  <= err_d;
            code_q <= code_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.next_pc   = cand;
    assign bus.stk_full  = full;
    assign bus.stk_empty = empty;
    assign bus.err       = err_q;
    assign bus.err_code  = code_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed plan followed by random ops.
module tb_pc_unit;
    import pc_pkg::*;

    localparam int W  = 8;
    localparam int RV = 'h10;
    localparam int SD = 2;
    localparam int IM = 'h80;

`ifdef PC_BOUND_CHECK_EN
    localparam bit BCHK = 1'b1;
`else
    localparam bit BCHK = 1'b0;
`endif

    typedef struct {
        int nxt;
        int pc;
        int full;
        int empty;
        int err;
        int code;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_unit_if #(.W(W)) bus ();

    pc_unit #(
        .W           (W),
        .RESET_VEC   (8'h10),
        .STACK_DEPTH (SD),
        .IMEM_DEPTH  (IM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    int m_pc;
    int m_err;
    int m_code;
    int m_stk[$];

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_pc  = RV;
        m_err = 0;
        m_code = 0;
        m_stk.delete();
    endfunction

    task automatic step(bit ld, int op, int tgt, int off, bit clr);
        exp_t e;
        int   nw;
        int   f;
        int   sd;
        int   old;
        bit   psh;
        bit   pp;
        logic [2:0] opb;
        @(negedge clk);
        #1;
        opb         = op[2:0];
        bus.ld      = ld;
        bus.op      = pc_op_t'(opb);
        bus.target  = tgt[7:0];
        bus.offset  = off[7:0];
        bus.err_clr = clr;
        nw  = m_pc;
        f   = 0;
        psh = 1'b0;
        pp  = 1'b0;
        case (op)
            0: nw = (m_pc + 1) % 256;
            1: nw = tgt;
            2: begin
                sd = (off >= 128) ? off - 256 : off;
                nw = (m_pc + sd + 256) % 256;
            end
            3: if (m_stk.size() == SD) f = 1;
               else begin nw = tgt; psh = 1'b1; end
            4: if (m_stk.size() == 0) f = 2;
               else begin nw = m_stk[$]; pp = 1'b1; end
            5: nw = m_pc;
            default: f = 3;
        endcase
        if (BCHK && f == 0 && op < 5 && nw >= IM) begin
            f   = 4;
            nw  = m_pc;
            psh = 1'b0;
            pp  = 1'b0;
        end
        e.nxt = nw;
        if (ld) begin
            if (psh) m_stk.push_back((m_pc + 1) % 256);
            if (pp) m_stk.delete(m_stk.size() - 1);
            m_pc = nw;
        end
        old = m_err;
        if (clr) begin
            m_err  = 0;
            m_code = 0;
        end
        if (ld && f != 0) begin
            if (old == 0 || clr) m_code = f;
            m_err = 1;
        end
        e.pc    = m_pc;
        e.full  = (m_stk.size() == SD) ? 1 : 0;
        e.empty = (m_stk.size() == 0) ? 1 : 0;
        e.err   = m_err;
        e.code  = m_code;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() > 0) begin
                e = sb[0];
                chk("next_pc", bus.next_pc, e.nxt);
                @(posedge clk);
                #1;
                chk("pc", bus.pc, e.pc);
                chk("stk_full", bus.stk_full, e.full);
                chk("stk_empty", bus.stk_empty, e.empty);
                chk("err", bus.err, e.err);
                chk("err_code", bus.err_code, e.code);
                sb.delete(0);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int r;
        int op;
        bit ld;
        bus.ld      = 1'b0;
        bus.op      = HOLD;
        bus.target  = '0;
        bus.offset  = '0;
        bus.err_clr = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("rst_pc", bus.pc, RV);
        chk("rst_empty", bus.stk_empty, 1);
        chk("rst_full", bus.stk_full, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_code", bus.err_code, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 'h33, 0, 0);
        step(1, 0, 0, 0, 0);
        drain();
        #1;
        chk("pre_rst_pc", bus.pc, m_pc);
        rst = 1'b0;
        #1;
        chk("arst_pc", bus.pc, RV);
        chk("arst_empty", bus.stk_empty, 1);
        chk("arst_err", bus.err, 0);
        chk("arst_code", bus.err_code, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        step(1, 1, 'hFF, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 'h20, 0, 0);
        step(1, 2, 0, 'hFC, 0);
        step(1, 2, 0, 'h05, 0);
        step(1, 1, 'h20, 0, 0);
        step(1, 3, 'h40, 0, 0);
        step(1, 3, 'h50, 0, 0);
        step(1, 3, 'h60, 0, 0);
        step(1, 4, 0, 0, 0);
        step(1, 4, 0, 0, 0);
        step(1, 4, 0, 0, 0);
        step(1, 7, 0, 0, 1);
        step(1, 5, 0, 0, 1);
        step(1, 6, 0, 0, 0);
        step(0, 5, 0, 0, 0);
        step(1, 5, 0, 0, 1);
        step(1, 1, 'h20, 0, 0);
        step(1, 1, 'h90, 0, 0);
        step(1, 1, 'h7F, 0, 0);
        step(1, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 15);
            if (r < 4) op = 0;
            else if (r < 6) op = 1;
            else if (r < 8) op = 2;
            else if (r < 11) op = 3;
            else if (r < 14) op = 4;
            else if (r == 14) op = 5;
            else op = $urandom_range(6, 7);
            ld = ($urandom_range(0, 3) != 0);
            step(ld, op, $urandom_range(0, 255), $urandom_range(0, 255),
                 ld && ($urandom_range(0, 7) == 0));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
